// File: rtl/vreg_file_wb.sv
// vreg_file_wb: vector register file with a masked load port and a
// two-beat writeback sequencer for double-width ALU results.
//
// Compile-time option: RF_BYPASS_EN. When defined, a read of the pending
// high-beat destination during WB_HI returns the held high halves.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ld_valid/ld_ready        load handshake
//   ld_dst, ld_mask, ld_data load destination, per-lane enable, data
//   wb_valid/wb_ready        writeback handshake
//   wb_dst_lo, wb_dst_hi     destinations for low / high halves
//   wb_result                double-width result, 2*LANE_W per lane
//   wb_busy                  high while the high beat is pending
//   rd_addr_a/b, rd_data_a/b combinational read ports
//
// state | meaning
// IDLE  | accepting writeback (priority) or load
// WB_HI | committing held high halves to hold_dst
module vreg_file_wb #(
    parameter int NUM_REGS = 4,
    parameter int LANES    = 16,
    parameter int LANE_W   = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [AW-1:0]               ld_dst,
    input  logic [LANES-1:0]            ld_mask,
    input  logic [LANES*LANE_W-1:0]     ld_data,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [AW-1:0]               wb_dst_lo,
    input  logic [AW-1:0]               wb_dst_hi,
    input  logic [2*LANES*LANE_W-1:0]   wb_result,
    output logic                        wb_busy,
    input  logic [AW-1:0]               rd_addr_a,
    input  logic [AW-1:0]               rd_addr_b,
    output logic [LANES*LANE_W-1:0]     rd_data_a,
    output logic [LANES*LANE_W-1:0]     rd_data_b
);

    localparam int VLEN = LANES * LANE_W;

    typedef enum logic {IDLE, WB_HI} state_t;

    state_t            state, state_nxt;
    logic [VLEN-1:0]   regs [NUM_REGS];
    logic [VLEN-1:0]   hold, hold_nxt;
    logic [AW-1:0]     hold_dst, hold_dst_nxt;
    logic [VLEN-1:0]   wb_lo, wb_hi;

    // single internal write port shared by load, low beat and high beat
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [VLEN-1:0]   wr_data;
    logic [LANES-1:0]  wr_mask;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGS);
    endfunction

    always_comb begin
        wb_lo = '0;
        wb_hi = '0;
        for (int i = 0; i < LANES; i++) begin
            wb_lo[i*LANE_W +: LANE_W] = wb_result[i*2*LANE_W +: LANE_W];
            wb_hi[i*LANE_W +: LANE_W] = wb_result[i*2*LANE_W + LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            hold_dst <= '0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            hold_dst <= hold_dst_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold;
        hold_dst_nxt = hold_dst;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        wr_mask      = '0;
        wb_ready     = 1'b0;
        ld_ready     = 1'b0;
        wb_busy      = 1'b0;
        case (state)
            IDLE: begin
                wb_ready = 1'b1;
                ld_ready = !wb_valid;
                if (wb_valid) begin
                    wr_en        = 1'b1;
                    wr_addr      = wb_dst_lo;
                    wr_data      = wb_lo;
                    wr_mask      = '1;
                    hold_nxt     = wb_hi;
                    hold_dst_nxt = wb_dst_hi;
                    state_nxt    = WB_HI;
                end else if (ld_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = ld_dst;
                    wr_data = ld_data;
                    wr_mask = ld_mask;
                end
            end
            WB_HI: begin
                wb_busy   = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = hold_dst;
                wr_data   = hold;
                wr_mask   = '1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // out-of-range destinations are silently dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr_en && addr_ok(wr_addr)) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l])
                    regs[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (addr_ok(rd_addr_a)) rd_data_a = regs[rd_addr_a];
`ifdef RF_BYPASS_EN
        if (state == WB_HI && addr_ok(rd_addr_a) && rd_addr_a == hold_dst) rd_data_a = hold;
`endif
    end

    always_comb begin
        rd_data_b = '0;
        if (addr_ok(rd_addr_b)) rd_data_b = regs[rd_addr_b];
`ifdef RF_BYPASS_EN
        if (state == WB_HI && addr_ok(rd_addr_b) && rd_addr_b == hold_dst) rd_data_b = hold;
`endif
    end

endmodule

// File: tb/tb_vreg_file_wb.sv
module tb_vreg_file_wb;

    localparam int NR = 4;
    localparam int LN = 16;
    localparam int LW = 32;
    localparam int VL = LN * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [1:0]    ld_dst;
    logic [LN-1:0] ld_mask;
    logic [VL-1:0] ld_data;
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    wb_dst_lo;
    logic [1:0]    wb_dst_hi;
    logic [2*VL-1:0] wb_result;
    logic          wb_busy;
    logic [1:0]    rd_addr_a, rd_addr_b;
    logic [VL-1:0] rd_data_a, rd_data_b;

    int checks = 0;
    int failures = 0;

    // reference model: architectural register contents plus one pending high beat
    logic [VL-1:0] m_regs [NR];
    bit            m_busy;
    logic [VL-1:0] m_hold;
    int            m_hold_dst;
    logic          s_ld_ready;

    vreg_file_wb #(.NUM_REGS(NR), .LANES(LN), .LANE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst),
        .ld_mask(ld_mask), .ld_data(ld_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dst_lo(wb_dst_lo), .wb_dst_hi(wb_dst_hi),
        .wb_result(wb_result), .wb_busy(wb_busy),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [VL-1:0] obs, input logic [VL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] lane(input logic [VL-1:0] v, input int k);
        return v[k*LW +: LW];
    endfunction

    function automatic logic [VL-1:0] half(input logic [2*VL-1:0] r, input bit hi);
        logic [VL-1:0] h;
        for (int i = 0; i < LN; i++) h[i*LW +: LW] = r[i*2*LW + (hi ? LW : 0) +: LW];
        return h;
    endfunction

    function automatic logic [VL-1:0] m_read(input int a);
        if (a >= NR) return '0;
`ifdef RF_BYPASS_EN
        if (m_busy && a == m_hold_dst) return m_hold;
`endif
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_busy = 0;
        m_hold = '0;
        m_hold_dst = 0;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; wb_valid = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".wb_ready"}, VL'(wb_ready), VL'(!m_busy));
        chk({tag, ".ld_ready"}, VL'(ld_ready), VL'(!m_busy && !wb_valid));
        chk({tag, ".wb_busy"},  VL'(wb_busy),  VL'(m_busy));
        for (int a = 0; a < NR; a++) begin
            rd_addr_a = 2'(a);
            rd_addr_b = 2'(NR - 1 - a);
            #1;
            chk({tag, ".rd_a"}, rd_data_a, m_read(a));
            chk({tag, ".rd_b"}, rd_data_b, m_read(NR - 1 - a));
        end
    endtask

    // one clock: check outputs for current inputs, take the edge, apply the model
    task automatic step(input string tag);
        #1;
        s_ld_ready = ld_ready;
        check_state(tag);
        @(posedge clk); #1;
        if (m_busy) begin
            if (m_hold_dst < NR) m_regs[m_hold_dst] = m_hold;
            m_busy = 0;
        end else if (wb_valid) begin
            if (int'(wb_dst_lo) < NR) m_regs[wb_dst_lo] = half(wb_result, 0);
            m_hold = half(wb_result, 1);
            m_hold_dst = int'(wb_dst_hi);
            m_busy = 1;
        end else if (ld_valid && int'(ld_dst) < NR) begin
            for (int i = 0; i < LN; i++)
                if (ld_mask[i]) m_regs[ld_dst][i*LW +: LW] = ld_data[i*LW +: LW];
        end
    endtask

    initial begin
        int stalls;
        logic [VL-1:0] lo_exp, hi_exp;
        rst = 1; idle_inputs();
        ld_dst = '0; ld_mask = '0; ld_data = '0;
        wb_dst_lo = '0; wb_dst_hi = '0; wb_result = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst = 0;

        // masked loads
        ld_valid = 1; ld_dst = 2'd1; ld_mask = 16'hFFFF;
        for (int k = 0; k < LN; k++) ld_data[k*LW +: LW] = LW'(k);
        step("ld_full");
        ld_data = '1; ld_mask = 16'h00F0;
        step("ld_mask");
        idle_inputs();
        rd_addr_a = 2'd1; #1;
        chk("ld.lane5", VL'(lane(rd_data_a, 5)), VL'(32'hFFFFFFFF));
        chk("ld.lane3", VL'(lane(rd_data_a, 3)), VL'(32'd3));
        chk("ld.lane8", VL'(lane(rd_data_a, 8)), VL'(32'd8));
        step("ld_idle");

        // two-beat writeback lo=2 hi=3
        wb_valid = 1; wb_dst_lo = 2'd2; wb_dst_hi = 2'd3;
        for (int i = 0; i < LN; i++)
            wb_result[i*2*LW +: 2*LW] = {32'h8000_0000 + 32'(i), 32'h0000_0001 + 32'(i)};
        step("wb_acc");
        idle_inputs();
        rd_addr_a = 2'd2; #1;
        chk("wb.c1.busy", VL'(wb_busy), VL'(1));
        chk("wb.c1.reg2_l7", VL'(lane(rd_data_a, 7)), VL'(32'd8));
        step("wb_hi");
        rd_addr_a = 2'd3; #1;
        chk("wb.c2.busy", VL'(wb_busy), VL'(0));
        chk("wb.c2.reg3_l15", VL'(lane(rd_data_a, 15)), VL'(32'h8000_000F));
        step("wb_done");

        // collision: writeback wins, load waits two cycles
        wb_valid = 1; ld_valid = 1; wb_dst_lo = 2'd1; wb_dst_hi = 2'd2;
        ld_dst = 2'd0; ld_mask = 16'hFFFF;
        for (int i = 0; i < 2*LN; i++) wb_result[i*LW +: LW] = $urandom;
        for (int i = 0; i < LN; i++) ld_data[i*LW +: LW] = $urandom;
        stalls = 0;
        step("coll0");
        if (!s_ld_ready) stalls++;
        wb_valid = 0;
        for (int n = 0; n < 5; n++) begin
            step("coll");
            if (s_ld_ready) break;
            stalls++;
        end
        chk("coll.stalls", VL'(stalls), VL'(2));
        idle_inputs();
        rd_addr_a = 2'd0; #1;
        chk("coll.ld_data", rd_data_a, ld_data);
        step("coll_idle");

        // lo == hi destination
        wb_valid = 1; wb_dst_lo = 2'd0; wb_dst_hi = 2'd0;
        for (int i = 0; i < 2*LN; i++) wb_result[i*LW +: LW] = $urandom;
        lo_exp = half(wb_result, 0);
        hi_exp = half(wb_result, 1);
        step("same_acc");
        idle_inputs();
        rd_addr_a = 2'd0; #1;
`ifdef RF_BYPASS_EN
        chk("same.whb", rd_data_a, hi_exp);
`else
        chk("same.whb", rd_data_a, lo_exp);
`endif
        step("same_hi");
        rd_addr_a = 2'd0; #1;
        chk("same.final", rd_data_a, hi_exp);
        step("same_idle");

        // reset in WB_HI drops the high beat
        wb_valid = 1; wb_dst_lo = 2'd1; wb_dst_hi = 2'd2;
        for (int i = 0; i < 2*LN; i++) wb_result[i*LW +: LW] = $urandom;
        step("rst_acc");
        idle_inputs();
        rst = 1; #1;
        m_reset();
        check_state("rst_mid");
        @(posedge clk); #1;
        rst = 0;
        step("rst_rel0");
        step("rst_rel1");
        rd_addr_a = 2'd2; #1;
        chk("rst.no_hi", rd_data_a, '0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            wb_valid = ($urandom_range(0, 2) == 0);
            ld_valid = ($urandom_range(0, 1) == 1);
            wb_dst_lo = 2'($urandom);
            wb_dst_hi = 2'($urandom);
            ld_dst = 2'($urandom);
            ld_mask = ($urandom_range(0, 7) == 0) ? '0 : LN'($urandom);
            for (int i = 0; i < 2*LN; i++) wb_result[i*LW +: LW] = $urandom;
            for (int i = 0; i < LN; i++) ld_data[i*LW +: LW] = $urandom;
            step("rand");
        end
        idle_inputs();
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
